// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: FSM state encoding,
// requester index constants and a one-hot helper.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational round-robin picker: searches req starting just after `last`,
// wrapping modulo 4 and ending at `last` itself.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = last;
        // i == 4 wraps back to `last`, so the previous owner is searched last
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[last + 2'(i)]) begin
                found = 1'b1;
                idx   = last + 2'(i);
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of the shared 4-to-1 mux,
// with a bounded hold time so no requester can starve the others.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       sel1,
    output logic       sel2,
    output logic       valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        last;
    logic [1:0]        owner;
    logic [1:0]        pick_last;
    logic              pick_found;
    logic [1:0]        pick_idx;
    logic              release_now;

    assign owner = {sel1, sel2};

    // While granted, any re-arbitration happens on release, which makes the
    // current owner the new `last`; feeding it directly saves a cycle.
    assign pick_last   = (state == ARB_GRANT) ? owner : last;
    assign release_now = !req[owner] || (hold_cnt == HOLD_LAST);

    rr_pick4 u_pick (
        .req   (req),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            grant    <= 4'b0000;
            sel1     <= 1'b0;
            sel2     <= 1'b0;
            valid    <= 1'b0;
            hold_cnt <= '0;
            last     <= REQ_D;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state    <= ARB_GRANT;
                        grant    <= onehot4(pick_idx);
                        {sel1, sel2} <= pick_idx;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        last <= owner;
                        if (pick_found) begin
                            grant    <= onehot4(pick_idx);
                            {sel1, sel2} <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            state    <= ARB_IDLE;
                            grant    <= 4'b0000;
                            valid    <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
